// File: rtl/f_round_ctrl_if.sv
// rtl/f_round_ctrl_if.sv - G-operation handshake between the F-round sequencer and the G unit
interface f_round_ctrl_if;
    logic       g_valid;
    logic       g_ready;
    logic       g_ack;
    logic [3:0] rnd_ctr;
    logic [2:0] sub_ctr;

    modport master (
        output g_valid,
        output rnd_ctr,
        output sub_ctr,
        input  g_ready,
        input  g_ack
    );

    modport slave (
        input  g_valid,
        input  rnd_ctr,
        input  sub_ctr,
        output g_ready,
        output g_ack
    );
endinterface

// File: rtl/f_round_ctrl.sv
// rtl/f_round_ctrl.sv - BLAKE2b compression F sequencer (init, rounds, finalise); option F_ROUND_CTRL_HAZARD_WAIT_EN
module f_round_ctrl #(
    parameter int NUM_ROUNDS = 12,
    parameter int OUT_W      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           last_block,
    output logic           busy,
    output logic           done,
    output logic           init_en,
    output logic           init_last,
    output logic           fin_en,
    output logic [2:0]     fin_idx,
    f_round_ctrl_if.master g
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_DRAIN,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    state_t     state, state_n;
    logic [3:0] rnd_n;
    logic [2:0] sub_n;
    logic [2:0] fin_idx_n;
    logic       issue;
    logic       last_issue;
    logic       stall_n;
    logic       drain_clear;
    logic       busy_n, done_n, init_en_n, init_last_n, fin_en_n, g_valid_n;

    assign issue      = (state == S_ROUND) && g.g_valid && g.g_ready;
    assign last_issue = issue && (g.rnd_ctr == LAST_RND) && (g.sub_ctr == 3'd7);

`ifdef F_ROUND_CTRL_HAZARD_WAIT_EN
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam state_t ROUND_EXIT = S_DRAIN;

    logic [OUT_W-1:0] out_cnt, out_cnt_n;

    // Spurious acks with nothing outstanding are dropped rather than wrapping.
    always_comb begin
        out_cnt_n = out_cnt;
        if (issue && !g.g_ack) begin
            out_cnt_n = out_cnt + 1'b1;
        end else if (!issue && g.g_ack && (out_cnt != '0)) begin
            out_cnt_n = out_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_n;
        end
    end

    // Column->diagonal and round boundaries read v words still being written by the G pipe.
    assign stall_n = ((out_cnt_n != '0) &&
                      ((sub_n == 3'd4) || ((sub_n == 3'd0) && (rnd_n != 4'd0)))) ||
                     (out_cnt_n == OUT_MAX);
    assign drain_clear = (out_cnt == '0);
`else
    localparam state_t ROUND_EXIT = S_FIN;

    logic [OUT_W:0] unused_ack;
    assign unused_ack  = {(OUT_W + 1){g.g_ack}};
    assign stall_n     = 1'b0;
    assign drain_clear = 1'b1;
`endif

    always_comb begin
        state_n   = state;
        rnd_n     = g.rnd_ctr;
        sub_n     = g.sub_ctr;
        fin_idx_n = 3'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_INIT;
                end
            end
            S_INIT: begin
                state_n = S_ROUND;
                rnd_n   = 4'd0;
                sub_n   = 3'd0;
            end
            S_ROUND: begin
                if (last_issue) begin
                    state_n = ROUND_EXIT;
                end else if (issue) begin
                    if (g.sub_ctr == 3'd7) begin
                        sub_n = 3'd0;
                        rnd_n = g.rnd_ctr + 4'd1;
                    end else begin
                        sub_n = g.sub_ctr + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_clear) begin
                    state_n = S_FIN;
                end
            end
            S_FIN: begin
                fin_idx_n = fin_idx + 3'd1;
                if (fin_idx == 3'd7) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                rnd_n   = 4'd0;
                sub_n   = 3'd0;
            end
            default: begin
                state_n = S_IDLE;
                rnd_n   = 4'd0;
                sub_n   = 3'd0;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop.
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        init_en_n   = (state_n == S_INIT);
        init_last_n = (state == S_IDLE) && (state_n == S_INIT) && last_block;
        fin_en_n    = (state_n == S_FIN);
        g_valid_n   = (state_n == S_ROUND) && !stall_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            g.rnd_ctr <= 4'd0;
            g.sub_ctr <= 3'd0;
            g.g_valid <= 1'b0;
            fin_idx   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            init_en   <= 1'b0;
            init_last <= 1'b0;
            fin_en    <= 1'b0;
        end else begin
            state     <= state_n;
            g.rnd_ctr <= rnd_n;
            g.sub_ctr <= sub_n;
            g.g_valid <= g_valid_n;
            fin_idx   <= fin_idx_n;
            busy      <= busy_n;
            done      <= done_n;
            init_en   <= init_en_n;
            init_last <= init_last_n;
            fin_en    <= fin_en_n;
        end
    end

endmodule

// File: tb/tb_f_round_ctrl.sv
// tb/tb_f_round_ctrl.sv - directed self-checking bench for f_round_ctrl
module tb_f_round_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       last_block = 1'b0;
    logic       busy, done, init_en, init_last, fin_en;
    logic [2:0] fin_idx;

    f_round_ctrl_if gif ();

    f_round_ctrl #(.NUM_ROUNDS(12), .OUT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .last_block (last_block),
        .busy       (busy),
        .done       (done),
        .init_en    (init_en),
        .init_last  (init_last),
        .fin_en     (fin_en),
        .fin_idx    (fin_idx),
        .g          (gif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int r_init_cyc, r_issues, r_order_err, r_fin_cnt, r_fin_err, r_done_cnt, r_done_cyc;
    int r_hold_err, r_busy_after, r_hazard_err, r_max_cnt;
    bit r_init_last, r_stalled, r_fin_early, r_aborted;
    logic [14:0] r_abort_outs;

    function automatic logic [14:0] all_outs();
        return {busy, done, init_en, init_last, fin_en, fin_idx,
                gif.g_valid, gif.rnd_ctr, gif.sub_ctr};
    endfunction

    // Drives one block from a start pulse; samples and drives on the falling edge.
    task automatic run_block(input bit lb, input int stall_len, input bit pulse, input bit abort);
        int       stall_left = 0;
        int       cnt = 0;
        int       acks = 0;
        bit [2:0] pipe = 3'b000;
        bit       iss;
        r_init_cyc = 0; r_issues = 0; r_order_err = 0; r_fin_cnt = 0; r_fin_err = 0;
        r_done_cnt = 0; r_done_cyc = 0; r_hold_err = 0; r_busy_after = 0;
        r_hazard_err = 0; r_max_cnt = 0; r_init_last = 0; r_stalled = 0;
        r_fin_early = 0; r_aborted = 0; r_abort_outs = '1;
        @(negedge clk);
        start = 1'b1;
        last_block = lb;
        gif.g_ready = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 400; k++) begin
            start = 1'b0;
            last_block = ~last_block;
            if (abort && gif.g_valid && gif.rnd_ctr == 4'd7 && gif.sub_ctr == 3'd4) begin
                rst_n = 1'b0;
                #1;
                r_abort_outs = all_outs();
                r_aborted = 1'b1;
                break;
            end
            gif.g_ack = pipe[2];
            if (gif.g_ack) acks++;
            if (init_en) begin
                r_init_cyc = k;
                r_init_last = init_last;
            end
            gif.g_ready = 1'b1;
            if (stall_left > 0) begin
                gif.g_ready = 1'b0;
                stall_left--;
                if (gif.rnd_ctr != 4'd5 || gif.sub_ctr != 3'd2) r_hold_err++;
            end else if (stall_len > 0 && !r_stalled && gif.g_valid &&
                         gif.rnd_ctr == 4'd5 && gif.sub_ctr == 3'd2) begin
                gif.g_ready = 1'b0;
                stall_left = stall_len - 1;
                r_stalled = 1'b1;
            end
            iss = gif.g_valid && gif.g_ready;
            if (iss) begin
                if (gif.rnd_ctr != 4'(r_issues / 8) || gif.sub_ctr != 3'(r_issues % 8)) r_order_err++;
                if (cnt > 0 && (gif.sub_ctr == 3'd4 || (gif.sub_ctr == 3'd0 && gif.rnd_ctr != 4'd0)))
                    r_hazard_err++;
                r_issues++;
            end
            cnt = cnt + int'(iss) - int'(gif.g_ack);
            if (cnt > r_max_cnt) r_max_cnt = cnt;
            pipe = {pipe[1:0], iss};
            if (fin_en) begin
                if (fin_idx != 3'(r_fin_cnt)) r_fin_err++;
                if (r_fin_cnt == 0 && acks < 96) r_fin_early = 1'b1;
                r_fin_cnt++;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = k;
                if (pulse) start = 1'b1;
            end else if (pulse && busy && (k % 9 == 0)) begin
                start = 1'b1;
            end
            if (r_done_cyc != 0 && k > r_done_cyc && busy) r_busy_after++;
            if (r_done_cyc != 0 && k >= r_done_cyc + 6) break;
            @(negedge clk);
        end
        start = 1'b0;
        gif.g_ack = 1'b0;
    endtask

    task automatic test_reset();
        gif.g_ready = 1'b0;
        gif.g_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 15'd0) $display("FAIL reset_outs got=%h want=0", all_outs());
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs() !== 15'd0) $display("FAIL idle_outs got=%h want=0", all_outs());
        else n_pass++;
    endtask

    task automatic test_basic();
        run_block(1'b0, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_init_cyc !== 1) $display("FAIL init_cycle got=%0d want=1", r_init_cyc);
        else n_pass++;
        n_checks++;
        if (r_init_last !== 1'b0) $display("FAIL init_last0 got=%0d want=0", r_init_last);
        else n_pass++;
        n_checks++;
        if (r_issues !== 96) $display("FAIL issue_count got=%0d want=96", r_issues);
        else n_pass++;
        n_checks++;
        if (r_order_err !== 0) $display("FAIL issue_order errors got=%0d want=0", r_order_err);
        else n_pass++;
        n_checks++;
        if (r_fin_cnt !== 8 || r_fin_err !== 0)
            $display("FAIL fin_seq got=%0d cycles/%0d errs want=8/0", r_fin_cnt, r_fin_err);
        else n_pass++;
        n_checks++;
        if (r_done_cnt !== 1) $display("FAIL done_count got=%0d want=1", r_done_cnt);
        else n_pass++;
`ifndef F_ROUND_CTRL_HAZARD_WAIT_EN
        n_checks++;
        if (r_done_cyc !== 106) $display("FAIL done_cycle got=%0d want=106", r_done_cyc);
        else n_pass++;
`endif
        n_checks++;
        if (r_busy_after !== 0) $display("FAIL busy_after_done got=%0d want=0", r_busy_after);
        else n_pass++;
    endtask

    task automatic test_last_block();
        run_block(1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_init_last !== 1'b1) $display("FAIL init_last1 got=%0d want=1", r_init_last);
        else n_pass++;
        n_checks++;
        if (r_done_cnt !== 1 || r_issues !== 96)
            $display("FAIL last_block_run got=%0d done/%0d issues want=1/96", r_done_cnt, r_issues);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_block(1'b0, 3, 1'b0, 1'b0);
        n_checks++;
        if (r_stalled !== 1'b1 || r_hold_err !== 0)
            $display("FAIL stall_hold got=%0d stalled/%0d errs want=1/0", r_stalled, r_hold_err);
        else n_pass++;
        n_checks++;
        if (r_issues !== 96 || r_order_err !== 0)
            $display("FAIL stall_issues got=%0d/%0d errs want=96/0", r_issues, r_order_err);
        else n_pass++;
`ifndef F_ROUND_CTRL_HAZARD_WAIT_EN
        n_checks++;
        if (r_done_cyc !== 109) $display("FAIL stall_done_cycle got=%0d want=109", r_done_cyc);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        run_block(1'b0, 0, 1'b1, 1'b0);
        n_checks++;
        if (r_done_cnt !== 1) $display("FAIL b2b_done_count got=%0d want=1", r_done_cnt);
        else n_pass++;
        n_checks++;
        if (r_busy_after !== 0) $display("FAIL b2b_idle got=%0d busy cycles want=0", r_busy_after);
        else n_pass++;
        n_checks++;
        if (r_issues !== 96) $display("FAIL b2b_issues got=%0d want=96", r_issues);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_block(1'b0, 0, 1'b0, 1'b1);
        n_checks++;
        if (r_aborted !== 1'b1 || r_abort_outs !== 15'd0)
            $display("FAIL abort_outs got=%0d/%h want=1/0", r_aborted, r_abort_outs);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done got=%0d%0d want=00", done, busy);
        else n_pass++;
        rst_n = 1'b1;
        run_block(1'b0, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_done_cnt !== 1 || r_issues !== 96)
            $display("FAIL after_abort got=%0d done/%0d issues want=1/96", r_done_cnt, r_issues);
        else n_pass++;
`ifndef F_ROUND_CTRL_HAZARD_WAIT_EN
        n_checks++;
        if (r_done_cyc !== 106) $display("FAIL after_abort_cycle got=%0d want=106", r_done_cyc);
        else n_pass++;
`endif
    endtask

`ifdef F_ROUND_CTRL_HAZARD_WAIT_EN
    task automatic test_hazard();
        run_block(1'b0, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_hazard_err !== 0) $display("FAIL hazard_issue got=%0d want=0", r_hazard_err);
        else n_pass++;
        n_checks++;
        if (r_max_cnt > 7) $display("FAIL hazard_max_cnt got=%0d want<=7", r_max_cnt);
        else n_pass++;
        n_checks++;
        if (r_fin_early !== 1'b0 || r_fin_cnt !== 8)
            $display("FAIL hazard_fin got=%0d early/%0d fin want=0/8", r_fin_early, r_fin_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_last_block();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef F_ROUND_CTRL_HAZARD_WAIT_EN
        test_hazard();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
